// File: rtl/sprite_compositor.sv
// Two-stage pixel compositor: square sprites drawn over a bordered playfield, with
// frame-double-buffered sprite attributes and per-frame overlap reporting against slot 0.
module sprite_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int X_W = 11,
    parameter int Y_W = 10,
    parameter int SIZE_W = 8,
    parameter int SCREEN_W = 1440,
    parameter int SCREEN_H = 900,
    parameter int BORDER = 11,
    parameter logic [11:0] BORDER_RGB = 12'h0F0,
    parameter logic [11:0] BG_RGB = 12'h00B,
    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [X_W-1:0]         wr_x,
    input  logic [Y_W-1:0]         wr_y,
    input  logic [SIZE_W-1:0]      wr_size,
    input  logic [11:0]            wr_rgb,
    input  logic                   wr_visible,
    input  logic                   pix_valid,
    input  logic [X_W-1:0]         draw_x,
    input  logic [Y_W-1:0]         draw_y,
    output logic                   out_valid,
    output logic [3:0]             r,
    output logic [3:0]             g,
    output logic [3:0]             b,
    output logic [NUM_SPRITES-1:0] hit_mask,
    output logic [NUM_SPRITES-1:0] collide_mask
);

    localparam int XS = X_W + 2;
    localparam int YS = Y_W + 2;
    localparam logic [X_W-1:0] X_LO = X_W'(BORDER);
    localparam logic [X_W-1:0] X_HI = X_W'(SCREEN_W - 1 - BORDER);
    localparam logic [Y_W-1:0] Y_LO = Y_W'(BORDER);
    localparam logic [Y_W-1:0] Y_HI = Y_W'(SCREEN_H - 1 - BORDER);

    typedef struct packed {
        logic              vis;
        logic [11:0]       rgb;
        logic [SIZE_W-1:0] size;
        logic [Y_W-1:0]    y;
        logic [X_W-1:0]    x;
    } slot_t;

    slot_t sh_q  [NUM_SPRITES];
    slot_t act_q [NUM_SPRITES];

    logic                   wr_ok;
    logic [NUM_SPRITES-1:0] hit_d;
    logic [11:0]            spr_rgb_d;
    logic                   border_d;
    logic [11:0]            col_d;
    logic [NUM_SPRITES-1:0] pair_d;
    logic [NUM_SPRITES-1:0] acc_d;

    logic                   vld_p1_q;
    logic [NUM_SPRITES-1:0] hit_p1_q;
    logic [11:0]            spr_rgb_p1_q;
    logic                   border_p1_q;
    logic                   vld_p2_q;
    logic [NUM_SPRITES-1:0] hit_p2_q;
    logic [11:0]            rgb_p2_q;
    logic [NUM_SPRITES-1:0] acc_q;
    logic [NUM_SPRITES-1:0] collide_q;

    // Guard bits keep centre +/- half-size from wrapping near either screen edge.
    function automatic logic slot_hit(input slot_t s, input logic [X_W-1:0] px,
                                      input logic [Y_W-1:0] py);
        logic signed [XS-1:0] cx, hx, dx;
        logic signed [YS-1:0] cy, hy, dy;
        cx = signed'(XS'(s.x));
        hx = signed'(XS'(s.size >> 1));
        dx = signed'(XS'(px));
        cy = signed'(YS'(s.y));
        hy = signed'(YS'(s.size >> 1));
        dy = signed'(YS'(py));
        return s.vis && (cx - hx < dx) && (dx < cx + hx) && (cy - hy < dy) && (dy < cy + hy);
    endfunction

    assign wr_ok = ({1'b0, wr_idx} < (IDX_W + 1)'(NUM_SPRITES));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_q[i]  <= '0;
                act_q[i] <= '0;
            end
        end else begin
            if (frame_start) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    act_q[i] <= sh_q[i];
                end
            end
            if (wr_en && wr_ok) begin
                sh_q[wr_idx] <= '{vis: wr_visible, rgb: wr_rgb, size: wr_size, y: wr_y, x: wr_x};
            end
        end
    end

    // Stage 1: hit test; the winning colour is captured here so a promotion cannot change it.
    always_comb begin
        hit_d     = '0;
        spr_rgb_d = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (pix_valid && slot_hit(act_q[i], draw_x, draw_y)) begin
                hit_d[i]  = 1'b1;
                spr_rgb_d = act_q[i].rgb;
            end
        end
        border_d = (draw_x < X_LO) || (draw_x > X_HI) || (draw_y < Y_LO) || (draw_y > Y_HI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q     <= 1'b0;
            hit_p1_q     <= '0;
            spr_rgb_p1_q <= '0;
            border_p1_q  <= 1'b0;
        end else begin
            vld_p1_q     <= pix_valid;
            hit_p1_q     <= hit_d;
            spr_rgb_p1_q <= spr_rgb_d;
            border_p1_q  <= border_d;
        end
    end

    // Stage 2: colour select with blanking.
    always_comb begin
        col_d = border_p1_q ? BORDER_RGB : BG_RGB;
        if (|hit_p1_q) begin
            col_d = spr_rgb_p1_q;
        end
        if (!vld_p1_q) begin
            col_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2_q <= 1'b0;
            hit_p2_q <= '0;
            rgb_p2_q <= '0;
        end else begin
            vld_p2_q <= vld_p1_q;
            hit_p2_q <= vld_p1_q ? hit_p1_q : '0;
            rgb_p2_q <= col_d;
        end
    end

    // Overlap with the player is accumulated from the pixel currently on the outputs.
    always_comb begin
        pair_d = '0;
        if (vld_p2_q && hit_p2_q[0]) begin
            pair_d = hit_p2_q;
        end
        pair_d[0] = 1'b0;
        acc_d = acc_q | pair_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            collide_q <= '0;
        end else if (frame_start) begin
            acc_q     <= '0;
            collide_q <= acc_d;
        end else begin
            acc_q     <= acc_d;
        end
    end

    assign out_valid    = vld_p2_q;
    assign r            = rgb_p2_q[11:8];
    assign g            = rgb_p2_q[7:4];
    assign b            = rgb_p2_q[3:0];
    assign hit_mask     = hit_p2_q;
    assign collide_mask = collide_q;

endmodule
